// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-FF sync, per-channel debounce, press/release
// strobes, long-press detection and auto-repeat. All outputs registered.
module button_conditioner #(
    parameter int unsigned     WIDTH           = 5,
    parameter logic [WIDTH-1:0] INVERT_MASK    = '0,
    parameter int unsigned     DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned     HOLD_CYCLES     = 100000000,
    parameter int unsigned     REPEAT_CYCLES   = 20000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] long_press_o,
    output logic [WIDTH-1:0] held_o,
    output logic [WIDTH-1:0] repeat_p_o
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam bit          RepEn = (REPEAT_CYCLES > 0);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldSat  = HoldW'(HOLD_CYCLES);
    localparam logic [RepW-1:0]  RepLast  = RepW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic [WIDTH-1:0] sync1_q, sync2_q, s;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] press_q, press_d, release_q, release_d;
    logic [WIDTH-1:0] long_q, long_d, held_q, held_d, rep_q, rep_d;
    logic [DbW-1:0]   db_cnt_q   [WIDTH];
    logic [DbW-1:0]   db_cnt_d   [WIDTH];
    logic [HoldW-1:0] hold_cnt_q [WIDTH];
    logic [HoldW-1:0] hold_cnt_d [WIDTH];
    logic [RepW-1:0]  rep_cnt_q  [WIDTH];
    logic [RepW-1:0]  rep_cnt_d  [WIDTH];

    assign s = sync2_q ^ INVERT_MASK;

    always_comb begin
        logic fall;
        data_d     = data_q;
        held_d     = held_q;
        press_d    = '0;
        release_d  = '0;
        long_d     = '0;
        rep_d      = '0;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            fall = 1'b0;
            // Any cycle where the synced input agrees with the output restarts the count.
            if (s[i] != data_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    data_d[i]    = s[i];
                    db_cnt_d[i]  = '0;
                    press_d[i]   = s[i];
                    release_d[i] = ~s[i];
                    fall         = ~s[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end

            // Release takes priority over a long-press or repeat due in the same cycle.
            if (!data_q[i] || fall) begin
                hold_cnt_d[i] = '0;
                rep_cnt_d[i]  = '0;
                held_d[i]     = 1'b0;
            end else begin
                if (hold_cnt_q[i] != HoldSat) begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                end
                if (hold_cnt_q[i] == HoldLast) begin
                    long_d[i]    = 1'b1;
                    held_d[i]    = 1'b1;
                    rep_cnt_d[i] = '0;
                end else if (RepEn && held_q[i]) begin
                    if (rep_cnt_q[i] == RepLast) begin
                        rep_d[i]     = 1'b1;
                        rep_cnt_d[i] = '0;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // Reset value of the synchroniser reads as "not pressed" after inversion.
            sync1_q    <= INVERT_MASK;
            sync2_q    <= INVERT_MASK;
            data_q     <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            held_q     <= '0;
            rep_q      <= '0;
            db_cnt_q   <= '{default: '0};
            hold_cnt_q <= '{default: '0};
            rep_cnt_q  <= '{default: '0};
        end else begin
            sync1_q    <= data_in_i;
            sync2_q    <= sync1_q;
            data_q     <= data_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            held_q     <= held_d;
            rep_q      <= rep_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign data_out_o   = data_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign held_o       = held_q;
    assign repeat_p_o   = rep_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected strobe events are queued by the stimulus
// and popped by a monitor whenever any strobe output is active.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] din;
    logic [4:0] dout, press, rel, lp, held, rp;
    logic [4:0] dout2, press2, rel2, lp2, held2, rp2;

    button_conditioner #(
        .WIDTH(5), .INVERT_MASK(5'b01000), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .data_in_i(din), .data_out_o(dout), .press_o(press),
        .release_o(rel), .long_press_o(lp), .held_o(held), .repeat_p_o(rp)
    );

    button_conditioner #(
        .WIDTH(5), .INVERT_MASK(5'b01000), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
    ) dut_norep (
        .clk_i(clk), .rst_i(rst), .data_in_i(din), .data_out_o(dout2), .press_o(press2),
        .release_o(rel2), .long_press_o(lp2), .held_o(held2), .repeat_p_o(rp2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] p;
        logic [4:0] r;
        logic [4:0] l;
        logic [4:0] rp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   rep2_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int c, input logic [4:0] p, input logic [4:0] r,
                                 input logic [4:0] l, input logic [4:0] rpt);
        exp_t e;
        e.cyc = c;
        e.p   = p;
        e.r   = r;
        e.l   = l;
        e.rp  = rpt;
        q.push_back(e);
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every active strobe cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rp2 != 5'b0) rep2_seen = 1'b1;
        if ((press | rel | lp | rp) != 5'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'({press, rel, lp, rp}), 32'(0));
            end else begin
                e = q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                chk("strobe_vec", 32'({press, rel, lp, rp}), 32'({e.p, e.r, e.l, e.rp}));
            end
        end
    end

    initial begin
        int c;
        din = 5'b01000;
        rst = 1'b1;
        wait_n(3);
        chk("rst_data_out", 32'(dout), 32'(0));
        chk("rst_held", 32'(held), 32'(0));
        rst = 1'b0;
        wait_n(10);
        chk("idle_inverted_ch3", 32'(dout), 32'(0));

        // Clean press on ch0: level and strobe exactly 6 cycles after the input edge.
        c = cyc;
        din[0] = 1'b1;
        push(c + 6, 5'b00001, 5'b0, 5'b0, 5'b0);
        wait_n(5);
        chk("t1_before", 32'(dout[0]), 32'(0));
        wait_n(1);
        chk("t1_at", 32'(dout[0]), 32'(1));
        wait_n(4);
        din[0] = 1'b0;
        push(c + 16, 5'b0, 5'b00001, 5'b0, 5'b0);
        wait_n(10);
        chk("t1_released", 32'(dout), 32'(0));

        // Bouncing ch1: single press 6 cycles after the last edge.
        c = cyc;
        din[1] = 1'b1; wait_n(2);
        din[1] = 1'b0; wait_n(2);
        din[1] = 1'b1; wait_n(2);
        din[1] = 1'b0; wait_n(2);
        din[1] = 1'b1;
        push(c + 14, 5'b00010, 5'b0, 5'b0, 5'b0);
        wait_n(10);
        chk("t2_level", 32'(dout), 32'(5'b00010));
        din[1] = 1'b0;
        push(c + 24, 5'b0, 5'b00010, 5'b0, 5'b0);
        wait_n(10);

        // Long hold on ch2: long press, repeats, release suppresses the coincident repeat.
        c = cyc;
        din[2] = 1'b1;
        push(c + 6, 5'b00100, 5'b0, 5'b0, 5'b0);
        push(c + 26, 5'b0, 5'b0, 5'b00100, 5'b0);
        push(c + 34, 5'b0, 5'b0, 5'b0, 5'b00100);
        push(c + 42, 5'b0, 5'b0, 5'b0, 5'b00100);
        push(c + 50, 5'b0, 5'b0, 5'b0, 5'b00100);
        push(c + 58, 5'b0, 5'b0, 5'b0, 5'b00100);
        wait_n(40);
        chk("t3_held", 32'(held), 32'(5'b00100));
        chk("t3_held_norep", 32'(held2), 32'(5'b00100));
        wait_n(20);
        din[2] = 1'b0;
        push(c + 66, 5'b0, 5'b00100, 5'b0, 5'b0);
        wait_n(5);
        chk("t3_held_pre_release", 32'(held), 32'(5'b00100));
        wait_n(1);
        chk("t3_held_cleared", 32'(held), 32'(0));
        wait_n(12);

        // Active-low ch3.
        c = cyc;
        din[3] = 1'b0;
        push(c + 6, 5'b01000, 5'b0, 5'b0, 5'b0);
        wait_n(10);
        chk("t4_level", 32'(dout), 32'(5'b01000));
        din[3] = 1'b1;
        push(c + 16, 5'b0, 5'b01000, 5'b0, 5'b0);
        wait_n(10);

        // Simultaneous ch0/ch4 press, then reset mid-hold with inputs kept high.
        c = cyc;
        din[0] = 1'b1;
        din[4] = 1'b1;
        push(c + 6, 5'b10001, 5'b0, 5'b0, 5'b0);
        push(c + 26, 5'b0, 5'b0, 5'b10001, 5'b0);
        push(c + 34, 5'b0, 5'b0, 5'b0, 5'b10001);
        wait_n(38);
        rst = 1'b1;
        wait_n(1);
        chk("t6_rst_dout", 32'(dout), 32'(0));
        chk("t6_rst_held", 32'(held), 32'(0));
        chk("t6_rst_strobes", 32'({press, rel, lp, rp}), 32'(0));
        wait_n(2);
        rst = 1'b0;
        c = cyc;
        push(c + 6, 5'b10001, 5'b0, 5'b0, 5'b0);
        wait_n(5);
        chk("t6_before", 32'(dout), 32'(0));
        wait_n(1);
        chk("t6_at", 32'(dout), 32'(5'b10001));
        wait_n(4);
        din[0] = 1'b0;
        din[4] = 1'b0;
        push(c + 16, 5'b0, 5'b10001, 5'b0, 5'b0);
        wait_n(15);

        chk("queue_empty", 32'(q.size()), 32'(0));
        chk("norep_never_strobes", 32'(rep2_seen), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
